layer_mac_sequencer: RTL and testbench

Parametrised operand/neuron sequencer for one fully connected layer. It counts MAC operand acknowledgements per neuron and steps the operand index and neuron index. It marks the first and last operand of each neuron and raises a held layer-complete flag after the final neuron. It sits between the layer controller (start/done) and the shared MAC datapath (ack, operand selects, accumulator control), and generalises the fixed 3-count ack counter to arbitrary input/neuron counts with a start handshake.

---
 rtl/layer_mac_sequencer_if.sv | 39 +++
 rtl/layer_mac_sequencer.sv | 106 ++++++++++
 tb/tb_layer_mac_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_mac_sequencer_if.sv
// layer_mac_sequencer_if
// Bundles the layer-controller handshake and the MAC-datapath control
// signals of one fully connected layer sequencer.
//
// Handshake: start is a level request sampled on a falling clock edge only
// while the sequencer is idle or done; ack is a per-operand acceptance
// sampled on a falling edge only while running. Each sampled ack retires
// exactly one operand. ack_mac is a held level, not a pulse.
interface layer_mac_sequencer_if #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 2
);
    localparam int IW = ($clog2(N_IN + 1) < 1) ? 1 : $clog2(N_IN + 1);
    localparam int OW = ($clog2(N_OUT) < 1) ? 1 : $clog2(N_OUT);

    logic          start;
    logic          ack;
    logic [IW-1:0] sel_in;
    logic [OW-1:0] sel_out;
    logic          acc_clr;
    logic          acc_last;
    logic          is_bias;
    logic          neuron_done;
    logic          busy;
    logic          ack_mac;
    logic [1:0]    state_dbg;

    modport slave (
        input  start, ack,
        output sel_in, sel_out, acc_clr, acc_last, is_bias,
               neuron_done, busy, ack_mac, state_dbg
    );

    modport master (
        output start, ack,
        input  sel_in, sel_out, acc_clr, acc_last, is_bias,
               neuron_done, busy, ack_mac, state_dbg
    );
endinterface

// File: rtl/layer_mac_sequencer.sv
// layer_mac_sequencer
// Steps operand index (sel_in) and neuron index (sel_out) for one fully
// connected layer, one operand per MAC ack, and raises a held layer-complete
// flag (ack_mac) after the last operand of the last neuron.
// All state changes on the falling clock edge; rst is asynchronous, active high.
// Optional build macro LAYER_SEQ_BIAS_EN adds a bias operand slot at
// sel_in == N_IN to every neuron.
// state_dbg exposes the FSM state: 0 = IDLE, 1 = RUN, 2 = DONE.
module layer_mac_sequencer #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    layer_mac_sequencer_if.slave    bus
);
    localparam int IW = ($clog2(N_IN + 1) < 1) ? 1 : $clog2(N_IN + 1);
    localparam int OW = ($clog2(N_OUT) < 1) ? 1 : $clog2(N_OUT);

`ifdef LAYER_SEQ_BIAS_EN
    localparam int LAST_IN = N_IN;
`else
    localparam int LAST_IN = N_IN - 1;
`endif

    localparam logic [IW-1:0] LAST_IN_V  = IW'(LAST_IN);
    localparam logic [OW-1:0] LAST_OUT_V = OW'(N_OUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_sel_in;
    logic [OW-1:0] r_sel_out;
    logic          r_neuron_done;
    logic          r_ack_mac;

    logic          w_run;
    logic          w_is_bias;

    // Sequencer FSM: indices, neuron pulse and layer-complete flag.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_sel_in      <= '0;
            r_sel_out     <= '0;
            r_neuron_done <= 1'b0;
            r_ack_mac     <= 1'b0;
        end else begin
            r_neuron_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    // ack is ignored here; start restarts from operand 0 of neuron 0
                    if (bus.start) begin
                        r_state   <= S_RUN;
                        r_sel_in  <= '0;
                        r_sel_out <= '0;
                        r_ack_mac <= 1'b0;
                    end
                end
                S_RUN: begin
                    // start is ignored while running
                    if (bus.ack) begin
                        if (r_sel_in == LAST_IN_V) begin
                            r_sel_in      <= '0;
                            r_neuron_done <= 1'b1;
                            if (r_sel_out == LAST_OUT_V) begin
                                r_state   <= S_DONE;
                                r_ack_mac <= 1'b1;
                                r_sel_out <= '0;
                            end else begin
                                r_sel_out <= r_sel_out + OW'(1);
                            end
                        end else begin
                            r_sel_in <= r_sel_in + IW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_run = (r_state == S_RUN);

`ifdef LAYER_SEQ_BIAS_EN
    assign w_is_bias = w_run && (r_sel_in == IW'(N_IN));
`else
    assign w_is_bias = 1'b0;
`endif

    assign bus.sel_in      = r_sel_in;
    assign bus.sel_out     = r_sel_out;
    assign bus.acc_clr     = w_run && (r_sel_in == '0);
    assign bus.acc_last    = w_run && (r_sel_in == LAST_IN_V);
    assign bus.is_bias     = w_is_bias;
    assign bus.neuron_done = r_neuron_done;
    assign bus.busy        = w_run;
    assign bus.ack_mac     = r_ack_mac;
    assign bus.state_dbg   = r_state;
endmodule

// File: tb/tb_layer_mac_sequencer.sv
// tb_layer_mac_sequencer
// Bench for layer_mac_sequencer with N_IN=2, N_OUT=2. Works for both the
// default build and the LAYER_SEQ_BIAS_EN build.
module tb_layer_mac_sequencer;
  localparam int N_IN  = 2;
  localparam int N_OUT = 2;
  localparam int TIW   = 2;
  localparam int TOW   = 1;
`ifdef LAYER_SEQ_BIAS_EN
  localparam int TB_LAST = N_IN;
  localparam bit BIAS    = 1'b1;
`else
  localparam int TB_LAST = N_IN - 1;
  localparam bit BIAS    = 1'b0;
`endif
  localparam int OPS  = TB_LAST + 1;
  localparam int ACKS = N_OUT * OPS;
  localparam int W    = 2 + TOW + TIW + 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  layer_mac_sequencer_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  layer_mac_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // reference model
  logic [1:0]     m_st;
  logic [TIW-1:0] m_in;
  logic [TOW-1:0] m_out;
  logic           m_nd;
  logic           m_am;

  task automatic model_reset();
    m_st = ST_IDLE; m_in = '0; m_out = '0; m_nd = 1'b0; m_am = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic a);
    m_nd = 1'b0;
    if (m_st == ST_IDLE || m_st == ST_DONE) begin
      if (s) begin
        m_st = ST_RUN; m_in = '0; m_out = '0; m_am = 1'b0;
      end
    end else if (m_st == ST_RUN && a) begin
      if (int'(m_in) == TB_LAST) begin
        m_in = '0;
        m_nd = 1'b1;
        if (int'(m_out) == N_OUT - 1) begin
          m_st = ST_DONE; m_am = 1'b1; m_out = '0;
        end else begin
          m_out = m_out + 1'b1;
        end
      end else begin
        m_in = m_in + 1'b1;
      end
    end
  endtask

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_exp;
  logic [W-1:0] sb_act;
  logic [3:0]   sb_cexp;
  logic [3:0]   sb_cact;

  always @(negedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      sb_act = {bus.state_dbg, bus.sel_out, bus.sel_in, bus.neuron_done, bus.ack_mac};
      total++;
      if (sb_act !== sb_exp) begin
        bad++;
        $display("FAIL sb_state {st,out,in,nd,am}: got %b required %b", sb_act, sb_exp);
      end
      sb_cexp[3] = (sb_exp[6:5] == ST_RUN);
      sb_cexp[2] = sb_cexp[3] && (sb_exp[3:2] == 2'd0);
      sb_cexp[1] = sb_cexp[3] && (int'(sb_exp[3:2]) == TB_LAST);
      sb_cexp[0] = BIAS && sb_cexp[3] && (int'(sb_exp[3:2]) == N_IN);
      sb_cact = {bus.busy, bus.acc_clr, bus.acc_last, bus.is_bias};
      total++;
      if (sb_cact !== sb_cexp) begin
        bad++;
        $display("FAIL sb_comb {busy,clr,last,bias}: got %b required %b", sb_cact, sb_cexp);
      end
    end
  end

  // driver: inputs change on rising edge, DUT updates on falling edge
  task automatic drive_cycle(input logic s, input logic a);
    @(posedge clk);
    bus.start = s;
    bus.ack   = a;
    model_step(s, a);
    exp_q.push_back({m_st, m_out, m_in, m_nd, m_am});
    @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1);
    @(posedge clk);
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if ({bus.state_dbg, bus.sel_out, bus.sel_in, bus.neuron_done, bus.ack_mac, bus.busy,
         bus.acc_clr, bus.acc_last, bus.is_bias} !== '0) begin
      bad++;
      $display("FAIL async_reset: got st=%0d out=%0d in=%0d nd=%b am=%b busy=%b required all 0",
               bus.state_dbg, bus.sel_out, bus.sel_in, bus.neuron_done, bus.ack_mac, bus.busy);
    end
    @(posedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1);
      total++;
      if (bus.sel_in !== '0 || bus.sel_out !== '0) begin
        bad++;
        $display("FAIL idle_ack_%0d: got out=%0d in=%0d required 0,0", i, bus.sel_out, bus.sel_in);
      end
    end
  endtask

  task automatic test_full_pass();
    drive_cycle(1'b1, 1'b0);
    for (int k = 0; k < ACKS; k++) begin
      total++;
      if (int'(bus.sel_out) != k / OPS || int'(bus.sel_in) != k % OPS) begin
        bad++;
        $display("FAIL full_index_%0d: got (%0d,%0d) required (%0d,%0d)", k,
                 bus.sel_out, bus.sel_in, k / OPS, k % OPS);
      end
      total++;
      if (bus.is_bias !== (BIAS && (k % OPS == N_IN))) begin
        bad++;
        $display("FAIL full_bias_%0d: got %b required %b", k, bus.is_bias, BIAS && (k % OPS == N_IN));
      end
      drive_cycle(1'b0, 1'b1);
      total++;
      if (bus.neuron_done !== ((k + 1) % OPS == 0)) begin
        bad++;
        $display("FAIL full_ndone_%0d: got %b required %b", k, bus.neuron_done, (k + 1) % OPS == 0);
      end
    end
    total++;
    if (bus.ack_mac !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL full_complete: got am=%b busy=%b required am=1 busy=0", bus.ack_mac, bus.busy);
    end
  endtask

  task automatic test_gapped();
    int k;
    logic a;
    k = 0;
    drive_cycle(1'b1, 1'b0);
    for (int c = 0; c < 3 * ACKS + 6 && k < ACKS; c++) begin
      a = (c % 3 == 2);
      total++;
      if (int'(bus.sel_out) != k / OPS || int'(bus.sel_in) != k % OPS) begin
        bad++;
        $display("FAIL gap_index_c%0d: got (%0d,%0d) required (%0d,%0d)", c,
                 bus.sel_out, bus.sel_in, k / OPS, k % OPS);
      end
      drive_cycle(1'b0, a);
      if (a) k++;
      total++;
      if (bus.ack_mac !== (k == ACKS)) begin
        bad++;
        $display("FAIL gap_ackmac_c%0d: got %b required %b", c, bus.ack_mac, k == ACKS);
      end
    end
    total++;
    if (k != ACKS) begin
      bad++;
      $display("FAIL gap_budget: got %0d acks required %0d", k, ACKS);
    end
  endtask

  task automatic test_restart();
    drive_cycle(1'b1, 1'b1);
    total++;
    if (bus.ack_mac !== 1'b0 || bus.sel_out !== '0 || bus.sel_in !== '0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_from_done: got am=%b (%0d,%0d) busy=%b required am=0 (0,0) busy=1",
               bus.ack_mac, bus.sel_out, bus.sel_in, bus.busy);
    end
    drive_cycle(1'b1, 1'b1);
    total++;
    if (bus.sel_in !== TIW'(1) || bus.sel_out !== '0) begin
      bad++;
      $display("FAIL start_in_run: got (%0d,%0d) required (0,1)", bus.sel_out, bus.sel_in);
    end
    for (int k = 1; k < ACKS; k++) drive_cycle(1'b0, 1'b1);
    total++;
    if (bus.ack_mac !== 1'b1) begin
      bad++;
      $display("FAIL restart_complete: got am=%b required 1", bus.ack_mac);
    end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b1);
      total++;
      if (bus.sel_in !== '0 || bus.sel_out !== '0 || bus.ack_mac !== 1'b1 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL done_ack_%0d: got am=%b (%0d,%0d) busy=%b required am=1 (0,0) busy=0",
                 i, bus.ack_mac, bus.sel_out, bus.sel_in, bus.busy);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive_cycle(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b1);
    @(posedge clk);
    bus.start = 1'b0;
    bus.ack   = 1'b1;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if ({bus.state_dbg, bus.sel_out, bus.sel_in, bus.neuron_done, bus.ack_mac, bus.busy} !== '0) begin
      bad++;
      $display("FAIL mid_reset: got st=%0d (%0d,%0d) nd=%b am=%b busy=%b required all 0",
               bus.state_dbg, bus.sel_out, bus.sel_in, bus.neuron_done, bus.ack_mac, bus.busy);
    end
    @(negedge clk);
    #2;
    total++;
    if (bus.neuron_done !== 1'b0 || bus.ack_mac !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_hold: got nd=%b am=%b required 0 0", bus.neuron_done, bus.ack_mac);
    end
    @(posedge clk);
    rst = 1'b0;
    bus.ack = 1'b0;
    drive_cycle(1'b1, 1'b0);
    for (int k = 0; k < ACKS; k++) begin
      total++;
      if (bus.ack_mac !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_early_%0d: got am=%b required 0", k, bus.ack_mac);
      end
      drive_cycle(1'b0, 1'b1);
    end
    total++;
    if (bus.ack_mac !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_pass: got am=%b required 1", bus.ack_mac);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    rst = 1'b0;

    test_reset();
    test_full_pass();
    test_gapped();
    test_restart();
    test_mid_reset();

    repeat (2) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d entries left required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
